// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and constants for the mux scan driver
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_SEL = 4;
    localparam int SEL_W   = 2;
    localparam int DWELL_W = 8;

    function automatic logic is_last_sel(input logic [SEL_W-1:0] idx);
        return idx == SEL_W'(NUM_SEL - 1);
    endfunction

endpackage

// File: rtl/mux_scan_driver_if.sv
// rtl/mux_scan_driver_if.sv - scan request, mux stimulus/feedback and result bundle
interface mux_scan_driver_if;
    logic       start;
    logic [3:0] table_in;
    logic       f_in;
    logic [3:0] i;
    logic [1:0] s;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       mismatch;

    modport master (
        output start, table_in, f_in,
        input  i, s, busy, done, result, mismatch
    );

    modport slave (
        input  start, table_in, f_in,
        output i, s, busy, done, result, mismatch
    );
endinterface

// File: rtl/mux_scan_dwell_cnt.sv
// rtl/mux_scan_dwell_cnt.sv - dwell counter 0..DWELL-1 with clear and last-cycle flag
module mux_scan_dwell_cnt
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/mux_scan_driver.sv
// rtl/mux_scan_driver.sv - drives a 4x1 mux through all selects and captures F
// Optional comparator against the latched table: define MUX_SCAN_COMPARE_EN.
module mux_scan_driver
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_scan_driver_if.slave    bus
);

    state_t           state_q;
    logic [3:0]       tbl_q;
    logic [SEL_W-1:0] idx_q;
    logic [3:0]       result_q;
    logic [3:0]       i_q;
    logic [SEL_W-1:0] s_q;
    logic             busy_q;
    logic             done_q;
    logic             dwell_last;

    mux_scan_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q != DRIVE),
        .en_i   (state_q == DRIVE),
        .last_o (dwell_last)
    );

`ifdef MUX_SCAN_COMPARE_EN
    logic mismatch_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
        end else if (state_q == IDLE && bus.start) begin
            mismatch_q <= 1'b0;
        end else if (state_q == DRIVE && dwell_last && is_last_sel(idx_q)) begin
            // The bit-3 sample lands on this same edge, so splice it in directly.
            mismatch_q <= ({bus.f_in, result_q[2:0]} != tbl_q);
        end
    end

    assign bus.mismatch = mismatch_q;
`else
    assign bus.mismatch = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tbl_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            i_q      <= '0;
            s_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q  <= DRIVE;
                        tbl_q    <= bus.table_in;
                        idx_q    <= '0;
                        result_q <= '0;
                        i_q      <= bus.table_in;
                        s_q      <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (dwell_last) begin
                        result_q[idx_q] <= bus.f_in;
                        if (is_last_sel(idx_q)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            s_q     <= SEL_W'(NUM_SEL - 1);
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            s_q   <= idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    i_q     <= '0;
                    s_q     <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    i_q     <= '0;
                    s_q     <= '0;
                end
            endcase
        end
    end

    assign bus.i      = i_q;
    assign bus.s      = s_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule
